// File: rtl/pc_seq_ctrl.sv
// Program counter sequencer: owns the PC and a fetch/execute/interrupt FSM,
// arbitrating return > branch > increment and vectoring into interrupts.
module pc_seq_ctrl #(
  parameter int                  PC_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0] INT_VEC  = 10'h3FF,
  parameter logic [PC_WIDTH-1:0] RST_VEC  = 10'h000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                br_req_i,
  input  logic                ret_req_i,
  input  logic                int_req_i,
  input  logic                int_en_i,
  input  logic                stall_i,
  input  logic [PC_WIDTH-1:0] from_immed_i,
  input  logic [PC_WIDTH-1:0] from_stack_i,
  output logic [1:0]          pc_mux_sel_o,
  output logic                pc_ld_o,
  output logic                pc_inc_o,
  output logic [PC_WIDTH-1:0] pc_count_o,
  output logic                int_ack_o,
  output logic [PC_WIDTH-1:0] int_ret_pc_o
);

  typedef enum logic [1:0] {S_INIT, S_FETCH, S_EXEC, S_INTR} state_e;

  localparam logic [1:0] SEL_IMMED = 2'b00;
  localparam logic [1:0] SEL_STACK = 2'b01;
  localparam logic [1:0] SEL_INT   = 2'b10;
  localparam logic [1:0] SEL_RST   = 2'b11;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] iret_q, iret_d;
  logic                int_take;

  assign int_take = int_req_i & int_en_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  state_d = S_FETCH;
      S_FETCH: state_d = stall_i ? S_FETCH : S_EXEC;
      S_EXEC:  state_d = int_take ? S_INTR : S_FETCH;
      S_INTR:  state_d = S_FETCH;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    pc_mux_sel_o = SEL_IMMED;
    pc_ld_o      = 1'b0;
    pc_inc_o     = 1'b0;
    int_ack_o    = 1'b0;
    case (state_q)
      S_INIT: begin
        pc_mux_sel_o = SEL_RST;
        pc_ld_o      = 1'b1;
      end
      S_EXEC: begin
        if (ret_req_i) begin
          pc_mux_sel_o = SEL_STACK;
          pc_ld_o      = 1'b1;
        end else if (br_req_i) begin
          pc_ld_o      = 1'b1;
        end else begin
          pc_inc_o     = 1'b1;
        end
      end
      S_INTR: begin
        pc_mux_sel_o = SEL_INT;
        pc_ld_o      = 1'b1;
        int_ack_o    = 1'b1;
      end
      default: ;
    endcase
  end

  // The return address saved on interrupt entry is the PC EXEC is writing,
  // so a branch/return target wins over the plain increment here too.
  always_comb begin
    pc_d   = pc_q;
    iret_d = iret_q;
    case (state_q)
      S_INIT: pc_d = RST_VEC;
      S_EXEC: begin
        if (ret_req_i)     pc_d = from_stack_i;
        else if (br_req_i) pc_d = from_immed_i;
        else               pc_d = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
        if (int_take) iret_d = pc_d;
      end
      S_INTR: pc_d = INT_VEC;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q   <= RST_VEC;
      iret_q <= '0;
    end else begin
      pc_q   <= pc_d;
      iret_q <= iret_d;
    end
  end

  assign pc_count_o   = pc_q;
  assign int_ret_pc_o = iret_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: directed vector table, a persistent-interrupt
// sequence, and randomized traffic against a cycle-level reference model.
module tb_pc_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, br, ret, ireq, ien, stall;
  logic [9:0] immed, stack;
  logic [1:0] sel;
  logic       ld, inc, ack;
  logic [9:0] pc, iret;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_seq_ctrl dut (
    .clk_i(clk), .rst_i(rst), .br_req_i(br), .ret_req_i(ret),
    .int_req_i(ireq), .int_en_i(ien), .stall_i(stall),
    .from_immed_i(immed), .from_stack_i(stack),
    .pc_mux_sel_o(sel), .pc_ld_o(ld), .pc_inc_o(inc), .pc_count_o(pc),
    .int_ack_o(ack), .int_ret_pc_o(iret)
  );

  // ctl = {rst, br, ret, ireq, ien, stall}; eo = {sel[1:0], ld, inc, ack}
  typedef struct {
    logic [5:0] ctl;
    logic [9:0] imm;
    logic [9:0] stk;
    logic [4:0] eo;
    logic [9:0] pc;
    logic [9:0] iret;
  } vec_t;

  vec_t tv[$];

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] c, input logic [9:0] im, input logic [9:0] st);
    {rst, br, ret, ireq, ien, stall} = c;
    immed = im;
    stack = st;
  endtask

  // Reference model: phase 0=reset-vector load, 1=fetch, 2=execute, 3=interrupt entry
  int         m_phase;
  logic [9:0] m_pc, m_iret;

  task automatic model_out(output logic [4:0] eo);
    eo = 5'b00000;
    case (m_phase)
      0: eo = 5'b11100;
      2: eo = ret ? 5'b01100 : (br ? 5'b00100 : 5'b00010);
      3: eo = 5'b10101;
      default: eo = 5'b00000;
    endcase
  endtask

  task automatic model_step();
    logic [9:0] tgt;
    if (rst) begin
      m_phase = 0; m_pc = 10'h000; m_iret = 10'h000;
    end else begin
      case (m_phase)
        0: begin m_pc = 10'h000; m_phase = 1; end
        1: if (!stall) m_phase = 2;
        2: begin
          if (ret)     tgt = stack;
          else if (br) tgt = immed;
          else         tgt = 10'((int'(m_pc) + 1) % 1024);
          m_pc = tgt;
          if (ireq && ien) begin m_iret = tgt; m_phase = 3; end
          else m_phase = 1;
        end
        default: begin m_pc = 10'h3FF; m_phase = 1; end
      endcase
    end
  endtask

  initial begin
    int acks, b2b;
    logic prev_ack;
    logic [4:0] eo;

    tv.push_back('{6'b100000, 10'h000, 10'h000, 5'b11100, 10'h000, 10'h000});
    tv.push_back('{6'b000000, 10'h000, 10'h000, 5'b11100, 10'h000, 10'h000});
    tv.push_back('{6'b000000, 10'h000, 10'h000, 5'b00000, 10'h000, 10'h000});
    tv.push_back('{6'b000000, 10'h000, 10'h000, 5'b00010, 10'h000, 10'h000});
    tv.push_back('{6'b000000, 10'h000, 10'h000, 5'b00000, 10'h001, 10'h000});
    tv.push_back('{6'b010000, 10'h1A4, 10'h000, 5'b00100, 10'h001, 10'h000});
    tv.push_back('{6'b010001, 10'h111, 10'h000, 5'b00000, 10'h1A4, 10'h000});
    tv.push_back('{6'b000001, 10'h000, 10'h000, 5'b00000, 10'h1A4, 10'h000});
    tv.push_back('{6'b000001, 10'h000, 10'h000, 5'b00000, 10'h1A4, 10'h000});
    tv.push_back('{6'b000000, 10'h000, 10'h000, 5'b00000, 10'h1A4, 10'h000});
    tv.push_back('{6'b011001, 10'h055, 10'h2C0, 5'b01100, 10'h1A4, 10'h000});
    tv.push_back('{6'b000000, 10'h000, 10'h000, 5'b00000, 10'h2C0, 10'h000});
    tv.push_back('{6'b010000, 10'h030, 10'h000, 5'b00100, 10'h2C0, 10'h000});
    tv.push_back('{6'b000000, 10'h000, 10'h000, 5'b00000, 10'h030, 10'h000});
    tv.push_back('{6'b000110, 10'h000, 10'h000, 5'b00010, 10'h030, 10'h000});
    tv.push_back('{6'b000110, 10'h000, 10'h000, 5'b10101, 10'h031, 10'h031});
    tv.push_back('{6'b000110, 10'h000, 10'h000, 5'b00000, 10'h3FF, 10'h031});
    tv.push_back('{6'b000100, 10'h000, 10'h000, 5'b00010, 10'h3FF, 10'h031});
    tv.push_back('{6'b000000, 10'h000, 10'h000, 5'b00000, 10'h000, 10'h031});
    tv.push_back('{6'b001110, 10'h000, 10'h3FF, 5'b01100, 10'h000, 10'h031});
    tv.push_back('{6'b010000, 10'h123, 10'h000, 5'b10101, 10'h3FF, 10'h3FF});
    tv.push_back('{6'b000000, 10'h000, 10'h000, 5'b00000, 10'h3FF, 10'h3FF});
    tv.push_back('{6'b110000, 10'h0AA, 10'h000, 5'b00100, 10'h3FF, 10'h3FF});
    tv.push_back('{6'b000000, 10'h000, 10'h000, 5'b11100, 10'h000, 10'h000});
    tv.push_back('{6'b000000, 10'h000, 10'h000, 5'b00000, 10'h000, 10'h000});
    tv.push_back('{6'b000110, 10'h000, 10'h000, 5'b00010, 10'h000, 10'h000});
    tv.push_back('{6'b100000, 10'h000, 10'h000, 5'b10101, 10'h001, 10'h001});
    tv.push_back('{6'b000000, 10'h000, 10'h000, 5'b11100, 10'h000, 10'h000});

    drive(6'b100000, 10'h000, 10'h000);
    @(posedge clk); #1;

    foreach (tv[i]) begin
      drive(tv[i].ctl, tv[i].imm, tv[i].stk);
      @(negedge clk);
      check($sformatf("vec%0d strobes", i), {sel, ld, inc, ack}, tv[i].eo);
      check($sformatf("vec%0d pc", i), pc, tv[i].pc);
      check($sformatf("vec%0d int_ret_pc", i), iret, tv[i].iret);
      @(posedge clk); #1;
    end

    // Interrupt held high: one ack per instruction, never two in a row.
    drive(6'b100000, 10'h000, 10'h000);
    @(posedge clk); #1;
    drive(6'b000110, 10'h000, 10'h000);
    acks = 0; b2b = 0; prev_ack = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ack) acks++;
      if (ack && prev_ack) b2b++;
      prev_ack = ack;
      @(posedge clk); #1;
    end
    check("persistent int ack count", acks, 3);
    check("persistent int back-to-back acks", b2b, 0);

    // Randomized traffic against the reference model.
    drive(6'b100000, 10'h000, 10'h000);
    model_step();
    @(posedge clk); #1;
    for (int c = 0; c < 800; c++) begin
      rst   = ($urandom_range(0, 39) == 0);
      br    = 1'($urandom_range(0, 1));
      ret   = ($urandom_range(0, 3) == 0);
      ireq  = ($urandom_range(0, 3) == 0);
      ien   = 1'($urandom_range(0, 1));
      stall = ($urandom_range(0, 2) == 0);
      immed = 10'($urandom());
      stack = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom());
      @(negedge clk);
      model_out(eo);
      check($sformatf("rnd%0d strobes", c), {sel, ld, inc, ack}, eo);
      check($sformatf("rnd%0d pc", c), pc, m_pc);
      check($sformatf("rnd%0d int_ret_pc", c), iret, m_iret);
      check($sformatf("rnd%0d ld&inc", c), ld & inc, 0);
      model_step();
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
